// File: rtl/sap_bus_ctrl.sv
// Bus and register controller for the SAP-style computer: PC, general registers, registered ALU,
// debounced GO command path. Optional ALU carry/zero flags are built when ALU_FLAGS_EN is defined.
module sap_bus_ctrl #(
  parameter int DW     = 8,
  parameter int PCW    = 4,
  parameter int NREG   = 2,
  parameter int SELW   = 4,
  parameter int DB_LEN = 50000,
  parameter int PC_DIV = 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            GO,
  input  logic [SELW-1:0] SEL,
  input  logic            PRGM,
  input  logic            WE,
  input  logic            OE,
  input  logic [DW-1:0]   PRGM_IN,
  input  logic            EN,
  input  logic            HLT,
  input  logic [2:0]      OP,
  output logic [DW-1:0]   BUS_OUT,
  output logic [DW-1:0]   CURRENT,
  output logic [PCW-1:0]  COUNT,
  output logic            ON,
  output logic            ERR,
  output logic            CF,
  output logic            ZF
);

  localparam int DBW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;
  localparam int PSW = (PC_DIV > 1) ? $clog2(PC_DIV) : 1;
  localparam logic [SELW-1:0] SEL_ALU = SELW'(NREG + 1);

  // ---------------------------------------------------------------- debounce
  logic           sync1_q;
  logic           go_s_q;
  logic           go_db_q, go_db_d;
  logic           go_db_dly_q;
  logic           cmd_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    go_db_d  = go_db_q;
    db_cnt_d = '0;
    if (go_s_q != go_db_q) begin
      if (db_cnt_q == DBW'(DB_LEN - 1)) begin
        go_db_d = go_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q     <= 1'b0;
      go_s_q      <= 1'b0;
      go_db_q     <= 1'b0;
      go_db_dly_q <= 1'b0;
      db_cnt_q    <= '0;
      cmd_q       <= 1'b0;
    end else begin
      sync1_q     <= GO;
      go_s_q      <= sync1_q;
      go_db_q     <= go_db_d;
      go_db_dly_q <= go_db_q;
      db_cnt_q    <= db_cnt_d;
      // Only the press edge issues a command; release is silent.
      cmd_q       <= go_db_q & ~go_db_dly_q;
    end
  end

  // ---------------------------------------------------------------- state
  logic [DW-1:0]  regs_q [NREG];
  logic [DW-1:0]  regs_d [NREG];
  logic [DW-1:0]  alu_q, alu_d;
  logic [DW-1:0]  holder_q, holder_d;
  logic [DW-1:0]  cur_q;
  logic [PCW-1:0] pc_q, pc_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic           on_q;
  logic           err_q, err_d;

  logic [DW-1:0]  pc_just;
  logic [DW-1:0]  src_val;
  logic [DW-1:0]  wr_val;
  logic           sel_pc, sel_reg, sel_alu, src_ok;
  logic           pc_wr;
  logic           run;

  assign pc_just = DW'(pc_q) << (DW - PCW);
  assign sel_pc  = (SEL == '0);
  assign sel_alu = (SEL == SEL_ALU);
  assign src_ok  = sel_pc | sel_reg | sel_alu;
  assign wr_val  = PRGM ? PRGM_IN : holder_q;
  assign run     = EN & ~HLT;

  // Source mux shared by OE and CURRENT; invalid selects read as zero.
  always_comb begin
    src_val = '0;
    sel_reg = 1'b0;
    if (sel_pc) src_val = pc_just;
    if (sel_alu) src_val = alu_q;
    for (int i = 0; i < NREG; i++) begin
      if (SEL == SELW'(i + 1)) begin
        sel_reg = 1'b1;
        src_val = regs_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    holder_d = holder_q;
    pc_wr    = 1'b0;
    err_d    = 1'b0;
    if (cmd_q) begin
      if (PRGM || WE) begin
        if (sel_pc) begin
          pc_wr = 1'b1;
        end else if (sel_reg) begin
          for (int i = 0; i < NREG; i++) begin
            if (SEL == SELW'(i + 1)) regs_d[i] = wr_val;
          end
        end else begin
          err_d = 1'b1;
        end
      end else if (OE) begin
        if (src_ok) holder_d = src_val;
        else        err_d    = 1'b1;
      end
    end
  end

  // A PC write wins over the increment and restarts the prescaler.
  always_comb begin
    pc_d    = pc_q;
    presc_d = presc_q;
    if (pc_wr) begin
      pc_d    = wr_val[DW-1:DW-PCW];
      presc_d = '0;
    end else if (run) begin
      if (presc_q == PSW'(PC_DIV - 1)) begin
        presc_d = '0;
        pc_d    = pc_q + PCW'(1);
      end else begin
        presc_d = presc_q + PSW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- ALU
  logic [DW-1:0] r0, r1;
  assign r0 = regs_q[0];
  assign r1 = regs_q[1];

`ifdef ALU_FLAGS_EN
  logic [DW:0] alu_w;
  logic        alu_c;
  logic        cf_q, zf_q;

  always_comb begin
    alu_w = '0;
    case (OP)
      3'd0:    alu_w = {1'b0, r0} + {1'b0, r1};
      3'd1:    alu_w = {1'b0, r0} - {1'b0, r1};
      3'd2:    alu_w = {1'b0, r0} - (DW+1)'(1);
      3'd3:    alu_w = {1'b0, r0} + (DW+1)'(1);
      3'd4:    alu_w = {1'b0, ~r0};
      3'd5:    alu_w = {1'b0, r0 & r1};
      3'd6:    alu_w = {1'b0, r0 | r1};
      default: alu_w = {1'b0, r0 ^ r1};
    endcase
  end

  assign alu_d = alu_w[DW-1:0];
  assign alu_c = alu_w[DW];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      cf_q <= alu_c;
      zf_q <= (alu_d == '0);
    end
  end

  assign CF = cf_q;
  assign ZF = zf_q;
`else
  always_comb begin
    alu_d = '0;
    case (OP)
      3'd0:    alu_d = r0 + r1;
      3'd1:    alu_d = r0 - r1;
      3'd2:    alu_d = r0 - DW'(1);
      3'd3:    alu_d = r0 + DW'(1);
      3'd4:    alu_d = ~r0;
      3'd5:    alu_d = r0 & r1;
      3'd6:    alu_d = r0 | r1;
      default: alu_d = r0 ^ r1;
    endcase
  end

  assign CF = 1'b0;
  assign ZF = 1'b0;
`endif

  // ---------------------------------------------------------------- registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      alu_q    <= '0;
      holder_q <= '0;
      cur_q    <= '0;
      pc_q     <= '0;
      presc_q  <= '0;
      on_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      alu_q    <= alu_d;
      holder_q <= holder_d;
      cur_q    <= src_val;
      pc_q     <= pc_d;
      presc_q  <= presc_d;
      on_q     <= run;
      err_q    <= err_d;
    end
  end

  assign BUS_OUT = holder_q;
  assign CURRENT = cur_q;
  assign COUNT   = pc_q;
  assign ON      = on_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_sap_bus_ctrl.sv
// Directed bench for sap_bus_ctrl with a short debounce window (DB_LEN=4, PC_DIV=1).
module tb_sap_bus_ctrl;

  localparam int DW   = 8;
  localparam int PCW  = 4;
  localparam int NREG = 2;
  localparam int SELW = 4;

`ifdef ALU_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            GO = 1'b0;
  logic [SELW-1:0] SEL = '0;
  logic            PRGM = 1'b0;
  logic            WE = 1'b0;
  logic            OE = 1'b0;
  logic [DW-1:0]   PRGM_IN = '0;
  logic            EN = 1'b0;
  logic            HLT = 1'b0;
  logic [2:0]      OP = '0;
  logic [DW-1:0]   BUS_OUT;
  logic [DW-1:0]   CURRENT;
  logic [PCW-1:0]  COUNT;
  logic            ON;
  logic            ERR;
  logic            CF;
  logic            ZF;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int base = 0;
  logic [DW-1:0] exp_q[$];

  sap_bus_ctrl #(
    .DW(DW), .PCW(PCW), .NREG(NREG), .SELW(SELW), .DB_LEN(4), .PC_DIV(1)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .GO(GO), .SEL(SEL), .PRGM(PRGM), .WE(WE), .OE(OE),
    .PRGM_IN(PRGM_IN), .EN(EN), .HLT(HLT), .OP(OP), .BUS_OUT(BUS_OUT), .CURRENT(CURRENT),
    .COUNT(COUNT), .ON(ON), .ERR(ERR), .CF(CF), .ZF(ZF)
  );

  // clock / error-pulse counter
  always #10 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RESET_N && ERR === 1'b1) err_cnt++;
  end

  // ---------------------------------------------------------------- tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_cmd(input logic p, input logic w, input logic o,
                        input logic [SELW-1:0] sel, input logic [DW-1:0] din);
    @(negedge CLK);
    PRGM = p; WE = w; OE = o; SEL = sel; PRGM_IN = din;
    GO = 1'b1;
    tick(12);
    GO = 1'b0;
    tick(10);
    PRGM = 1'b0; WE = 1'b0; OE = 1'b0;
  endtask

  task automatic check_sel(input string tag, input logic [SELW-1:0] sel, input logic [DW-1:0] exp);
    SEL = sel;
    tick(2);
    check(tag, CURRENT, exp);
  endtask

  task automatic oe_cmd(input string tag, input logic [SELW-1:0] sel, input logic [DW-1:0] exp);
    exp_q.push_back(exp);
    do_cmd(1'b0, 1'b0, 1'b1, sel, '0);
    check(tag, BUS_OUT, exp_q.pop_front());
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    SEL = 4'd15;
    tick(3);
    check("rst_bus", BUS_OUT, 0);
    check("rst_cur", CURRENT, 0);
    check("rst_count", COUNT, 0);
    check("rst_on", ON, 0);
    check("rst_err", ERR, 0);
    check("rst_cf", CF, 0);
    check("rst_zf", ZF, 0);

    // Release reset with GO already held: exactly one command (invalid PRGM -> ERR).
    PRGM = 1'b1; GO = 1'b1;
    tick(2);
    RESET_N = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      check($sformatf("rst_go_err_c%0d", i), ERR, (i == 8));
    end
    tick(10);
    check("rst_go_once", err_cnt, 1);
    GO = 1'b0;
    tick(10);
    check("rst_go_release", err_cnt, 1);

    // Bounce rejection
    base = err_cnt;
    repeat (3) begin
      GO = 1'b1; tick(3);
      GO = 1'b0; tick(3);
    end
    tick(8);
    check("bounce_none", err_cnt, base);
    GO = 1'b1; tick(10);
    check("bounce_held", err_cnt, base + 1);
    GO = 1'b0; tick(10);
    check("bounce_release", err_cnt, base + 1);
    PRGM = 1'b0;

    // Bus transfer
    do_cmd(1'b1, 1'b0, 1'b0, 4'd1, 8'h2C);
    check_sel("prgm_r0", 4'd1, 8'h2C);
    oe_cmd("oe_r0_bus", 4'd1, 8'h2C);
    do_cmd(1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
    check_sel("we_r1", 4'd2, 8'h2C);
    check_sel("we_r0_kept", 4'd1, 8'h2C);
    OP = 3'd0;
    check_sel("alu_add", 4'd3, 8'h58);
    check("alu_add_cf", CF, 0);
    check("alu_add_zf", ZF, 0);
    oe_cmd("oe_alu_bus", 4'd3, 8'h58);

    // ALU edges
    do_cmd(1'b1, 1'b0, 1'b0, 4'd1, 8'hFF);
    do_cmd(1'b1, 1'b0, 1'b0, 4'd2, 8'h01);
    OP = 3'd0;
    check_sel("add_wrap", 4'd3, 8'h00);
    check("add_wrap_cf", CF, FL);
    check("add_wrap_zf", ZF, FL);
    OP = 3'd1;
    check_sel("sub_ff_01", 4'd3, 8'hFE);
    check("sub_ff_01_cf", CF, 0);
    do_cmd(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    OP = 3'd2;
    check_sel("dec_zero", 4'd3, 8'hFF);
    check("dec_zero_cf", CF, FL);
    check("dec_zero_zf", ZF, 0);
    OP = 3'd1;
    check_sel("sub_borrow", 4'd3, 8'hFF);
    check("sub_borrow_cf", CF, FL);
    OP = 3'd3;
    check_sel("inc", 4'd3, 8'h01);
    check("inc_cf", CF, 0);
    OP = 3'd4;
    check_sel("not", 4'd3, 8'hFF);
    OP = 3'd5;
    check_sel("and", 4'd3, 8'h00);
    check("and_zf", ZF, FL);
    OP = 3'd6;
    check_sel("or", 4'd3, 8'h01);
    OP = 3'd7;
    check_sel("xor", 4'd3, 8'h01);

    // PC counting, wrap, halt
    check("pc_start", COUNT, 0);
    EN = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      check($sformatf("pc_k%0d", k), COUNT, 32'(k % 16));
    end
    check("on_run", ON, 1);
    HLT = 1'b1;
    tick(1);
    check("hlt_count", COUNT, 2);
    check("hlt_on", ON, 0);
    tick(2);
    check("hlt_hold", COUNT, 2);

    // PC write while counting overrides that edge's increment
    HLT = 1'b0; PRGM = 1'b1; SEL = 4'd0; PRGM_IN = 8'h90; GO = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      check($sformatf("pc_wr_c%0d", i), COUNT, (i < 8) ? 32'(2 + i) : 32'(9 + i - 8));
    end
    GO = 1'b0; EN = 1'b0;
    tick(10);
    PRGM = 1'b0;
    check("pc_stopped", COUNT, 4'hB);
    oe_cmd("oe_pc_bus", 4'd0, 8'hB0);

    // Errors and no-op
    base = err_cnt;
    do_cmd(1'b1, 1'b0, 1'b0, 4'd3, 8'h55);
    check("err_prgm_alu", err_cnt, base + 1);
    check("err_prgm_bus", BUS_OUT, 8'hB0);
    check_sel("err_prgm_r0", 4'd1, 8'h00);
    check_sel("err_prgm_r1", 4'd2, 8'h01);
    do_cmd(1'b0, 1'b0, 1'b1, 4'd9, 8'h00);
    check("err_oe_inv", err_cnt, base + 2);
    check("err_oe_bus", BUS_OUT, 8'hB0);
    do_cmd(1'b0, 1'b1, 1'b0, 4'd12, 8'h00);
    check("err_we_inv", err_cnt, base + 3);
    check("err_we_count", COUNT, 4'hB);
    do_cmd(1'b0, 1'b0, 1'b0, 4'd1, 8'h77);
    check("noop_err", err_cnt, base + 3);
    check_sel("noop_r0", 4'd1, 8'h00);
    check_sel("inv_sel_cur", 4'd9, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
